// File: rtl/if_stage_if.sv
// ----------------------------------------------------------------------------
// if_stage_if
// Bundles the instruction-fetch stage's decode feedback, its
// instruction-memory port and its IF/ID outputs.
//   stall        decode -> IF   hold PC and IF/ID
//   redirect     decode -> IF   control transfer taken this cycle
//   redirect_pc  decode -> IF   target address; bits [1:0] are ignored
//   imem_addr    IF -> imem     current PC
//   imem_rdata   imem -> IF     instruction word, combinational in imem_addr
//   id_instr     IF -> decode   IF/ID instruction
//   id_pc        IF -> decode   PC of id_instr
//   id_pc4       IF -> decode   id_pc + 4
//   id_valid     IF -> decode   real fetched instruction, not an injected nop
//   pc_err       IF -> system   sticky out-of-range fetch flag
// modport master: the fetch stage; modport slave: its environment.
// ----------------------------------------------------------------------------
interface if_stage_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        pc_err;

    modport master (
        input  stall, redirect, redirect_pc, imem_rdata,
        output imem_addr, id_instr, id_pc, id_pc4, id_valid, pc_err
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_rdata,
        input  imem_addr, id_instr, id_pc, id_pc4, id_valid, pc_err
    );
endinterface

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction fetch stage of the pipelined MIPS core. Owns the PC, drives
// the combinational instruction memory and registers the fetched word into
// the IF/ID register. Decode feeds back stall and redirect requests.
//
// Ports:
//   clk    input   rising-edge clock
//   reset  input   synchronous, active-high reset
//   bus    if_stage_if.master  (stall/redirect/redirect_pc/imem_rdata in;
//          imem_addr/id_instr/id_pc/id_pc4/id_valid/pc_err out)
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   IM_WORDS  instruction memory depth in 32-bit words
//
// Build option:
//   IF_DELAY_SLOT_EN  defined: a redirect still latches the word being
//                     fetched (MIPS delay slot). Undefined: a redirect
//                     flushes IF/ID to a nop with id_valid = 0.
// ----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_WORDS = 1024
) (
    input  logic       clk,
    input  logic       reset,
    if_stage_if.master bus
);

    // Fetch window size in bytes; 33 bits so large depths cannot wrap.
    localparam logic [32:0] IM_BYTES = 33'(IM_WORDS) * 33'd4;

    logic [31:0] pc_q,       pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q,    id_pc_d;
    logic [31:0] id_pc4_q,   id_pc4_d;
    logic        id_valid_q, id_valid_d;
    logic        pc_err_q,   pc_err_d;

    logic [31:0] pc_ofs;
    logic [31:0] pc_plus4;
    logic        in_range;
    logic [31:0] fetch_word;

    always_comb begin
        // PCs below RESET_PC wrap to a huge offset and fall out of range.
        pc_ofs     = pc_q - RESET_PC;
        in_range   = ({1'b0, pc_ofs} < IM_BYTES);
        fetch_word = in_range ? bus.imem_rdata : 32'h0;
        pc_plus4   = pc_q + 32'd4;

        pc_d       = pc_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;
        pc_err_d   = pc_err_q;

        // A stall holds everything and silently drops a coincident redirect.
        if (!bus.stall) begin
            id_pc_d  = pc_q;
            id_pc4_d = pc_plus4;
            pc_err_d = pc_err_q | ~in_range;
            if (bus.redirect) begin
                pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
`ifdef IF_DELAY_SLOT_EN
                id_instr_d = fetch_word;
                id_valid_d = in_range;
`else
                id_instr_d = 32'h0;
                id_valid_d = 1'b0;
`endif
            end else begin
                pc_d       = pc_plus4;
                id_instr_d = fetch_word;
                id_valid_d = in_range;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            id_instr_q <= 32'h0;
            id_pc_q    <= 32'h0;
            id_pc4_q   <= 32'h0;
            id_valid_q <= 1'b0;
            pc_err_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
            pc_err_q   <= pc_err_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.id_instr  = id_instr_q;
    assign bus.id_pc     = id_pc_q;
    assign bus.id_pc4    = id_pc4_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.pc_err    = pc_err_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    int checks = 0;
    int passes = 0;

    exp_t sb[$];

    // Reference state for the full-size instance
    logic [31:0] m_pc, m_instr, m_idpc, m_idpc4;
    logic        m_valid, m_err;

    if_stage_if bus_a ();
    if_stage_if bus_b ();

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign bus_a.imem_rdata = imem_word(bus_a.imem_addr);
    assign bus_b.imem_rdata = imem_word(bus_b.imem_addr);

    if_stage #(.RESET_PC(32'h0000_3000), .IM_WORDS(1024)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    if_stage #(.RESET_PC(32'h0000_3000), .IM_WORDS(4)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Drive one cycle on the full-size instance, predict its outputs, then
    // compare the prediction popped from the scoreboard after the edge.
    task automatic step(input logic rs, input logic st, input logic rd, input logic [31:0] rpc);
        exp_t        e;
        logic [31:0] fw;
        logic        inr;
        rst_a             = rs;
        bus_a.stall       = st;
        bus_a.redirect    = rd;
        bus_a.redirect_pc = rpc;
        inr = (m_pc >= 32'h0000_3000) && (m_pc <= 32'h0000_3FFC);
        fw  = inr ? imem_word(m_pc) : 32'h0;
        if (rs) begin
            m_pc = 32'h3000; m_instr = 0; m_idpc = 0; m_idpc4 = 0; m_valid = 0; m_err = 0;
        end else if (!st) begin
            m_idpc  = m_pc;
            m_idpc4 = m_pc + 32'd4;
            m_err   = m_err | !inr;
            if (rd) begin
`ifdef IF_DELAY_SLOT_EN
                m_instr = fw;  m_valid = inr;
`else
                m_instr = 0;   m_valid = 1'b0;
`endif
                m_pc = {rpc[31:2], 2'b00};
            end else begin
                m_instr = fw; m_valid = inr;
                m_pc = m_pc + 32'd4;
            end
        end
        e = '{m_pc, m_instr, m_idpc, m_idpc4, m_valid, m_err};
        sb.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        assert (sb.size() != 0) passes++;
        else $error("FAIL sb_empty: observed %0d expected >0", sb.size());
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_imem_addr", bus_a.imem_addr, e.addr);
            chk("sb_id_instr",  bus_a.id_instr,  e.instr);
            chk("sb_id_pc",     bus_a.id_pc,     e.pc);
            chk("sb_id_pc4",    bus_a.id_pc4,    e.pc4);
            chk("sb_id_valid",  {31'b0, bus_a.id_valid}, {31'b0, e.valid});
            chk("sb_pc_err",    {31'b0, bus_a.pc_err},   {31'b0, e.err});
        end
    endtask

    task automatic sstep(input logic rs, input logic st, input logic rd, input logic [31:0] rpc);
        rst_b             = rs;
        bus_b.stall       = st;
        bus_b.redirect    = rd;
        bus_b.redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_a.stall = 0; bus_a.redirect = 0; bus_a.redirect_pc = 0;
        bus_b.stall = 0; bus_b.redirect = 0; bus_b.redirect_pc = 0;
        m_pc = 0; m_instr = 0; m_idpc = 0; m_idpc4 = 0; m_valid = 0; m_err = 0;

        // Reset state
        step(1, 0, 0, 0);
        chk("rst_imem_addr", bus_a.imem_addr, 32'h3000);
        chk("rst_id_valid",  {31'b0, bus_a.id_valid}, 32'h0);

        // Sequential fetch
        step(0, 0, 0, 0);
        chk("seq_addr1", bus_a.imem_addr, 32'h3004);
        chk("seq_idpc1", bus_a.id_pc, 32'h3000);
        chk("seq_vld1",  {31'b0, bus_a.id_valid}, 32'h1);
        step(0, 0, 0, 0);
        chk("seq_addr2",  bus_a.imem_addr, 32'h3008);
        chk("seq_idpc2",  bus_a.id_pc, 32'h3004);
        chk("seq_instr2", bus_a.id_instr, 32'hC0DE_3004);

        // Stall for three cycles at 0x3008
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            chk("stall_addr",  bus_a.imem_addr, 32'h3008);
            chk("stall_idpc",  bus_a.id_pc, 32'h3004);
            chk("stall_instr", bus_a.id_instr, 32'hC0DE_3004);
        end
        step(0, 0, 0, 0);
        chk("stall_resume", bus_a.imem_addr, 32'h300C);

        // Redirect from PC 0x3004 to 0x3043 -> 0x3040
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h3043);
        chk("redir_addr", bus_a.imem_addr, 32'h3040);
        chk("redir_slot_pc", bus_a.id_pc, 32'h3004);
`ifdef IF_DELAY_SLOT_EN
        chk("redir_slot_instr", bus_a.id_instr, 32'hC0DE_3004);
        chk("redir_slot_vld",   {31'b0, bus_a.id_valid}, 32'h1);
`else
        chk("redir_flush_instr", bus_a.id_instr, 32'h0);
        chk("redir_flush_vld",   {31'b0, bus_a.id_valid}, 32'h0);
`endif
        step(0, 0, 0, 0);
        chk("redir_target_instr", bus_a.id_instr, 32'hC0DE_3040);
        chk("redir_target_pc",    bus_a.id_pc, 32'h3040);

        // Simultaneous stall + redirect: redirect dropped
        step(0, 1, 1, 32'h3100);
        chk("stallredir_held", bus_a.imem_addr, 32'h3044);
        step(0, 0, 1, 32'h3100);
        chk("redir_again", bus_a.imem_addr, 32'h3100);
        step(0, 0, 0, 0);
        chk("redir_again_pc", bus_a.id_pc, 32'h3100);

        // Wraparound at top of address space
        step(0, 0, 1, 32'hFFFF_FFFE);
        chk("wrap_addr", bus_a.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_err0", {31'b0, bus_a.pc_err}, 32'h0);
        step(0, 0, 0, 0);
        chk("wrap_addr0", bus_a.imem_addr, 32'h0);
        chk("wrap_pc4",   bus_a.id_pc4, 32'h0);
        chk("wrap_err1",  {31'b0, bus_a.pc_err}, 32'h1);
        step(0, 0, 1, 32'h3000);
        step(0, 0, 0, 0);
        chk("wrap_err_sticky", {31'b0, bus_a.pc_err}, 32'h1);

        // Reset mid-stall at PC 0x3020
        step(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("pre_rst_addr", bus_a.imem_addr, 32'h3020);
        step(1, 1, 0, 0);
        chk("midrst_addr",  bus_a.imem_addr, 32'h3000);
        chk("midrst_instr", bus_a.id_instr, 32'h0);
        chk("midrst_pc",    bus_a.id_pc, 32'h0);
        chk("midrst_pc4",   bus_a.id_pc4, 32'h0);
        chk("midrst_vld",   {31'b0, bus_a.id_valid}, 32'h0);
        chk("midrst_err",   {31'b0, bus_a.pc_err}, 32'h0);

        // Out-of-range on a 4-word memory
        sstep(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) sstep(0, 0, 0, 0);
        chk("oor_addr",    bus_b.imem_addr, 32'h3010);
        chk("oor_err_pre", {31'b0, bus_b.pc_err}, 32'h0);
        chk("oor_last_ok", {31'b0, bus_b.id_valid}, 32'h1);
        sstep(0, 0, 0, 0);
        chk("oor_instr", bus_b.id_instr, 32'h0);
        chk("oor_vld",   {31'b0, bus_b.id_valid}, 32'h0);
        chk("oor_pc",    bus_b.id_pc, 32'h3010);
        chk("oor_err",   {31'b0, bus_b.pc_err}, 32'h1);
        sstep(0, 0, 1, 32'h3000);
        chk("oor_recover_addr", bus_b.imem_addr, 32'h3000);
        chk("oor_err_hold1",    {31'b0, bus_b.pc_err}, 32'h1);
        sstep(0, 0, 0, 0);
        chk("oor_recover_vld",  {31'b0, bus_b.id_valid}, 32'h1);
        chk("oor_recover_instr", bus_b.id_instr, 32'hC0DE_3000);
        chk("oor_err_hold2",    {31'b0, bus_b.pc_err}, 32'h1);
        sstep(1, 0, 0, 0);
        chk("oor_err_clear",    {31'b0, bus_b.pc_err}, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
